// File: rtl/ad9958_spi_serializer.sv
// Serializes a right-justified 1-8 byte payload MSB-first onto the AD9958 serial port.
// Supports single-bit (sdio[0]) and quad-lane modes behind a trigger/busy handshake.
module ad9958_spi_serializer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [4:0]  packs_to_send,
  input  logic [63:0] data_input,
  input  logic        quad_mode,
  output logic        busy,
  output logic        done,
  output logic        cs_n,
  output logic        sclk,
  output logic [3:0]  sdio
);

  localparam int unsigned PMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned PW   = (PMAX < 2) ? 1 : $clog2(PMAX);
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [6:0]    beats_q, beats_d;
  logic [63:0]   shreg_q, shreg_d;
  logic          quad_q, quad_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic [3:0]    sdio_q, sdio_d;

  logic [3:0]    n_eff;
  logic [6:0]    n_bits;
  logic [63:0]   shreg_load;
  logic [63:0]   shreg_next;

  function automatic logic [3:0] lanes(input logic [3:0] top, input logic quad);
    return quad ? top : {3'b000, top[3]};
  endfunction

  // Oversized lengths clamp to a full 64-bit payload; the load aligns bit 8N-1 to bit 63.
  assign n_eff      = (packs_to_send > 5'd8) ? 4'd8 : packs_to_send[3:0];
  assign n_bits     = {n_eff, 3'b000};
  assign shreg_load = data_input << (7'd64 - n_bits);
  assign shreg_next = quad_q ? {shreg_q[59:0], 4'h0} : {shreg_q[62:0], 1'b0};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    beats_d = beats_q;
    shreg_d = shreg_q;
    quad_d  = quad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    sdio_d  = sdio_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger && (n_eff != 4'd0)) begin
          state_d = ST_SETUP;
          phase_d = '0;
          shreg_d = shreg_load;
          quad_d  = quad_mode;
          beats_d = quad_mode ? {2'b00, n_eff, 1'b0} : n_bits;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sdio_d  = lanes(shreg_load[63:60], quad_mode);
        end
      end
      ST_SETUP, ST_LOW: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (beats_q == 7'd1) begin
            state_d = ST_HOLD;
          end else begin
            beats_d = beats_q - 7'd1;
            shreg_d = shreg_next;
            sdio_d  = lanes(shreg_next[63:60], quad_q);
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          cs_n_d  = 1'b1;
          sdio_d  = '0;
          state_d = ST_GAP;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      beats_q <= '0;
      shreg_q <= '0;
      quad_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      beats_q <= beats_d;
      shreg_q <= shreg_d;
      quad_q  <= quad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdio = sdio_q;

endmodule

// File: tb/tb_ad9958_spi_serializer.sv
// Bench for ad9958_spi_serializer: directed and random frames against a payload-level model.
module tb_ad9958_spi_serializer;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        trigger;
  logic [4:0]  packs_to_send;
  logic [63:0] data_input;
  logic        quad_mode;
  logic        busy, done, cs_n, sclk;
  logic [3:0]  sdio;

  ad9958_spi_serializer #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .trigger       (trigger),
    .packs_to_send (packs_to_send),
    .data_input    (data_input),
    .quad_mode     (quad_mode),
    .busy          (busy),
    .done          (done),
    .cs_n          (cs_n),
    .sclk          (sclk),
    .sdio          (sdio)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pin-level observer: what the DDS would latch on each SCLK rising edge.
  logic [3:0]  beat_q[$];
  int unsigned busy_cnt = 0, done_cnt = 0, frames = 0, viol = 0;
  int unsigned high_run = 0, last_high_run = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [3:0]  prev_sdio = 4'h0;

  always @(negedge clock) begin
    if (sclk && !prev_sclk) beat_q.push_back(sdio);
    if (sclk && prev_sclk && (sdio != prev_sdio)) viol++;
    if (sclk && cs_n) viol++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (!cs_n && prev_cs) begin
      frames++;
      last_high_run = high_run;
    end
    high_run  = cs_n ? high_run + 1 : 0;
    prev_sclk = sclk;
    prev_cs   = cs_n;
    prev_sdio = sdio;
  end

  int unsigned s_beat, s_busy, s_done, s_frames, s_viol;

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic snap();
    s_beat   = beat_q.size();
    s_busy   = busy_cnt;
    s_done   = done_cnt;
    s_frames = frames;
    s_viol   = viol;
  endtask

  task automatic start(input int unsigned n, input logic [63:0] d, input logic q, input int unsigned hold);
    trigger       = 1'b1;
    packs_to_send = 5'(n);
    data_input    = d;
    quad_mode     = q;
    repeat (hold) tick();
    trigger = 1'b0;
    check_eq("busy_on_trigger_drop", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    int unsigned k = 0;
    while (!done && k < 3000) begin
      tick();
      k++;
    end
    check_eq("done_seen", 64'(done), 64'd1);
  endtask

  function automatic int unsigned frame_len(input int unsigned n, input logic q);
    int unsigned ne = (n > 8) ? 8 : n;
    int unsigned b  = q ? 2 * ne : 8 * ne;
    return CLK_DIV * (2 * b + 1) + GAP_CYCLES;
  endfunction

  task automatic verify(input int unsigned n, input logic [63:0] d, input logic q);
    int unsigned ne = (n > 8) ? 8 : n;
    int unsigned b  = q ? 2 * ne : 8 * ne;
    logic [63:0] exp_val = (ne == 8) ? d : (d & ((64'd1 << (8 * ne)) - 64'd1));
    logic [63:0] val = '0;
    logic [2:0]  up  = '0;
    for (int unsigned i = s_beat; i < beat_q.size(); i++) begin
      if (q) val = (val << 4) | 64'(beat_q[i]);
      else begin
        val = (val << 1) | 64'(beat_q[i][0]);
        up  = up | beat_q[i][3:1];
      end
    end
    check_eq("beat_count", 64'(beat_q.size() - s_beat), 64'(b));
    check_eq("payload", val, exp_val);
    check_eq("idle_lanes", 64'(up), 64'd0);
    check_eq("busy_cycles", 64'(busy_cnt - s_busy), 64'(frame_len(n, q)));
    check_eq("done_pulses", 64'(done_cnt - s_done), 64'd1);
    check_eq("cs_frames", 64'(frames - s_frames), 64'd1);
    check_eq("sclk_data_rules", 64'(viol - s_viol), 64'd0);
  endtask

  task automatic frame(input int unsigned n, input logic [63:0] d, input logic q, input int unsigned hold);
    snap();
    start(n, d, q, hold);
    wait_done();
    verify(n, d, q);
    tick();
  endtask

  initial begin
    int unsigned len;
    int unsigned k;
    reset_n       = 1'b0;
    trigger       = 1'b0;
    packs_to_send = '0;
    data_input    = '0;
    quad_mode     = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_cs_n", 64'(cs_n), 64'd1);
    check_eq("rst_sclk", 64'(sclk), 64'd0);
    check_eq("rst_sdio", 64'(sdio), 64'd0);
    reset_n = 1'b1;
    tick();

    frame(1, 64'h01, 1'b0, 1);
    frame(4, 64'h1234_5678, 1'b1, 1);
    frame(3, 64'hFFFF_FFFF_FFAB_CDEF, 1'b0, 1);
    frame(20, 64'h0123_4567_89AB_CDEF, 1'b1, 1);
    frame(2, 64'hA5C3, 1'b0, 2);

    // Zero-length request must not touch the pins.
    snap();
    trigger = 1'b1;
    packs_to_send = 5'd0;
    tick();
    trigger = 1'b0;
    repeat (10) tick();
    check_eq("n0_frames", 64'(frames - s_frames), 64'd0);
    check_eq("n0_busy", 64'(busy_cnt - s_busy), 64'd0);
    check_eq("n0_cs_n", 64'(cs_n), 64'd1);

    // Abort an 8-byte frame at its third beat.
    snap();
    start(8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1);
    k = 0;
    while ((beat_q.size() - s_beat) < 3 && k < 500) begin
      tick();
      k++;
    end
    check_eq("abort_reached_beat3", 64'(beat_q.size() - s_beat), 64'd3);
    reset_n = 1'b0;
    #1;
    check_eq("abort_cs_n", 64'(cs_n), 64'd1);
    check_eq("abort_sclk", 64'(sclk), 64'd0);
    check_eq("abort_sdio", 64'(sdio), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    frame(1, 64'h5A, 1'b0, 1);

    // Back-to-back: trigger sampled on the done edge is dropped, one cycle later is taken.
    len = frame_len(2, 1'b0);
    snap();
    start(2, 64'h3C96, 1'b0, 1);
    repeat (len - 1) tick();
    trigger       = 1'b1;
    packs_to_send = 5'd1;
    data_input    = 64'hC4;
    quad_mode     = 1'b1;
    tick();
    check_eq("b2b_ignored_busy", 64'(busy), 64'd0);
    check_eq("b2b_done", 64'(done), 64'd1);
    verify(2, 64'h3C96, 1'b0);
    snap();
    tick();
    trigger = 1'b0;
    check_eq("b2b_accepted_busy", 64'(busy), 64'd1);
    wait_done();
    verify(1, 64'hC4, 1'b1);
    check_eq("b2b_cs_gap", 64'(last_high_run), 64'(GAP_CYCLES + 1));
    tick();

    for (int unsigned i = 0; i < 16; i++) begin
      frame($urandom_range(1, 12), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
